// File: rtl/fetch_queue.sv
// Fetch-to-decode circular queue with valid/allowin handshakes and flush.
// Optional FQ_BYPASS_EN: an entry arriving at an empty queue appears on the output in the same cycle.
module fetch_queue #(
    parameter int BUS_WD = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_WD = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BUS_WD-1:0] in_bus,
    output logic              in_allowin,
    output logic              out_valid,
    output logic [BUS_WD-1:0] out_bus,
    input  logic              out_allowin,
    input  logic              flush,
    output logic [CNT_WD-1:0] count
);

    localparam int PTR_WD = $clog2(DEPTH);

    logic [BUS_WD-1:0] mem_q [DEPTH];
    logic [PTR_WD-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WD-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_WD-1:0] count_q, count_d;

    logic bypass;
    logic push;
    logic pop;

    always_comb begin
        in_allowin = (count_q != CNT_WD'(DEPTH));
`ifdef FQ_BYPASS_EN
        bypass    = (count_q == '0) && in_valid && !flush;
        out_valid = ((count_q != '0) && !flush) || bypass;
        out_bus   = bypass ? in_bus : mem_q[rd_ptr_q];
`else
        bypass    = 1'b0;
        out_valid = (count_q != '0) && !flush;
        out_bus   = mem_q[rd_ptr_q];
`endif
        // A bypassed entry taken by decode never touches storage.
        push = in_valid && in_allowin && !flush && !(bypass && out_allowin);
        pop  = out_valid && out_allowin && !bypass;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not cleared; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_bus;
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue of expected entries is filled on accepted pushes
// and drained as the DUT hands entries to decode.
module tb_fetch_queue;

    localparam int BUS_WD = 64;
    localparam int DEPTH  = 4;
    localparam int CNT_WD = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [BUS_WD-1:0] in_bus = '0;
    logic              in_allowin;
    logic              out_valid;
    logic [BUS_WD-1:0] out_bus;
    logic              out_allowin = 1'b0;
    logic              flush = 1'b0;
    logic [CNT_WD-1:0] count;

    fetch_queue #(.BUS_WD(BUS_WD), .DEPTH(DEPTH), .CNT_WD(CNT_WD)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bus(in_bus),
        .in_allowin(in_allowin), .out_valid(out_valid), .out_bus(out_bus),
        .out_allowin(out_allowin), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;
    logic accepted;
    logic [BUS_WD-1:0] sb [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BUS_WD-1:0] pl(input int n);
        logic [31:0] pc, inst;
        pc   = 32'hBFC0_0000 + 32'(n * 4);
        inst = 32'h2401_0001 + 32'(n);
        return {pc, inst};
    endfunction

    // One clock: drive, check combinational outputs against the scoreboard, then advance it.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [BUS_WD-1:0] b, input logic oa);
        logic exp_byp, exp_ov, do_pop;
        logic [BUS_WD-1:0] exp_bus;
        reset = r; flush = f; in_valid = iv; in_bus = b; out_allowin = oa;
        #1;
`ifdef FQ_BYPASS_EN
        exp_byp = (sb.size() == 0) && iv && !f;
`else
        exp_byp = 1'b0;
`endif
        exp_ov  = ((sb.size() != 0) && !f) || exp_byp;
        exp_bus = exp_byp ? b : ((sb.size() != 0) ? sb[0] : '0);
        if (chk_en) begin
            check("count", 64'(count), 64'(sb.size()));
            check("in_allowin", 64'(in_allowin), 64'(sb.size() != DEPTH));
            check("out_valid", 64'(out_valid), 64'(exp_ov));
            if (exp_ov) check("out_bus", out_bus, exp_bus);
        end
        accepted = iv && (sb.size() != DEPTH) && !f && !r;
        do_pop   = exp_ov && oa && !exp_byp;
        @(posedge clk);
        if (r || f) sb.delete();
        else if (!(exp_byp && oa)) begin
            if (do_pop) void'(sb.pop_front());
            if (accepted) sb.push_back(b);
        end
        if (r) chk_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        check("reset_count", 64'(count), 64'd0);
        check("reset_allowin", 64'(in_allowin), 64'd1);

        // First fetch after reset, decode always ready.
        step(0, 0, 1, pl(0), 1);
        step(0, 0, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        check("first_drained", 64'(count), 64'd0);

        // Fill past capacity with decode stalled, then drain in order.
        n = 1;
        repeat (6) begin step(0, 0, 1, pl(n), 0); if (accepted) n++; end
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_allowin", 64'(in_allowin), 64'd0);
        repeat (8) begin step(0, 0, (n <= 5), pl(n), 1); if (accepted) n++; end

        // Steady push+pop for 3*DEPTH entries with one entry resident.
        n = 100;
        step(0, 0, 1, pl(n), 0); n++;
        repeat (3 * DEPTH) begin step(0, 0, 1, pl(n), 1); if (accepted) n++; end
        check("steady_count", 64'(count), 64'd1);
        repeat (2) step(0, 0, 0, '0, 1);

        // Flush with three queued and a new entry offered.
        n = 200;
        repeat (3) begin step(0, 0, 1, pl(n), 0); n++; end
        step(0, 1, 1, pl(n), 1); n++;
        check("flush_count", 64'(count), 64'd0);
        repeat (3) step(0, 0, 0, '0, 1);

        // Reset mid-stream with two queued.
        n = 300;
        repeat (2) begin step(0, 0, 1, pl(n), 0); n++; end
        step(1, 0, 0, '0, 0);
        check("midreset_count", 64'(count), 64'd0);
        check("midreset_valid", 64'(out_valid), 64'd0);
        step(0, 0, 1, pl(n), 1); n++;
        step(0, 0, 0, '0, 1);

        // Hold a single head entry for ten stalled cycles, then release.
        step(0, 0, 1, pl(400), 0);
        repeat (10) step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 1);
        check("hold_released", 64'(count), 64'd0);

        // Random traffic with occasional flush.
        n = 500;
        repeat (300) begin
            step(0, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), pl(n),
                 1'($urandom_range(0, 1)));
            if (accepted) n++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter BUS_WD, default 64; width of one fetch-to-decode bus entry ({pc, inst}).
REQ-002 Parameter DEPTH, default 4; entry count, power of two, range 2..16.
REQ-003 Parameter CNT_WD, default 3; count width, equal to clog2(DEPTH+1).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream (fetch) entry present.
REQ-007 in_bus  input  BUS_WD  upstream entry payload.
REQ-008 in_allowin  output  1  queue accepts an entry this cycle.
REQ-009 out_valid  output  1  head entry presented to decode.
REQ-010 out_bus  output  BUS_WD  head entry payload.
REQ-011 out_allowin  input  1  decode accepts the head entry this cycle.
REQ-012 flush  input  1  branch/redirect; discard all queued entries.
REQ-013 count  output  CNT_WD  number of stored entries.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH x BUS_WD with read pointer, write pointer and count registers.
REQ-015 in_allowin SHALL equal (count != DEPTH); no pass-through when full, even if a pop occurs that cycle.
REQ-016 Push SHALL occur when in_valid && in_allowin && !flush; entry written at write pointer, which advances by 1.
REQ-017 out_valid SHALL equal (count != 0) && !flush, except as extended by REQ-027; out_bus SHALL be the entry at the read pointer.
REQ-018 Pop SHALL occur when out_valid && out_allowin; read pointer advances by 1.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0 with no bubble.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and move both pointers, including at count==1.
REQ-021 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or underflow.
REQ-022 Latency, bypass disabled: an entry pushed in cycle N SHALL be visible on out_valid/out_bus in cycle N+1 at the earliest.
REQ-023 flush SHALL take priority over push and pop: next cycle count=0 and both pointers=0; any in_valid entry in the flush cycle SHALL be dropped.
REQ-024 out_bus SHALL hold stable while out_valid is high and out_allowin is low.
REQ-025 Entries SHALL leave in push order; none duplicated or lost except by flush.

Reset
REQ-026 While reset is high at a clock edge: count=0, pointers=0, so out_valid=0, in_allowin=1, count output=0; storage contents need not be cleared; reset overrides flush, push and pop; reset mid-stream discards all entries.

Configuration
REQ-027 Macro FQ_BYPASS_EN defined: when count==0, in_valid=1 and flush=0, out_valid SHALL be 1 and out_bus SHALL equal in_bus combinationally; if out_allowin=1 that cycle the entry is consumed and not stored (count stays 0), else it is stored normally.
REQ-028 Macro FQ_BYPASS_EN undefined: no combinational in-to-out path; REQ-022 latency applies.

Verification
REQ-029 Reset, then in_valid=1 with bus 0x..BFC00000/0x24010001, out_allowin=1 -> out_valid first high one cycle later (same cycle with FQ_BYPASS_EN), correct payload, count returns to 0.
REQ-030 DEPTH=4, out_allowin=0, push 5 consecutive entries -> in_allowin drops after 4th, count=4, 5th held upstream; release out_allowin -> entries 1..5 emerge in order.
REQ-031 Steady push+pop each cycle for 3*DEPTH entries -> count constant, pointers wrap 3 times, no entry lost or reordered.
REQ-032 count=3, flush asserted with in_valid=1 and out_allowin=1 -> out_valid=0 that cycle, next cycle count=0, flushed-cycle entry absent from output.
REQ-033 count=2, reset asserted for one cycle mid-stream -> next cycle count=0, out_valid=0, in_allowin=1; subsequent push behaves as REQ-029.
REQ-034 Hold out_allowin=0 with count=1 for 10 cycles -> out_bus unchanged throughout, then one pop on release.
